// File: rtl/sobel_pixel_counter_if.sv
// Pixel-stream control/status bundle for sobel_pixel_counter.
// With SOBEL_CNT_BORDER_EN defined, the bundle also carries Border.
interface sobel_pixel_counter_if #(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8
);
  // Start/Enable/Clear are level-sampled on the rising edge and carry no
  // ready: Start is honoured only in IDLE, Enable only in RUN, and Clear
  // always wins.
  logic                Start;
  logic                Enable;
  logic                Clear;
  logic [COL_BITS-1:0] Col;
  logic [ROW_BITS-1:0] Row;
  logic                LineEnd;
  logic                FrameEnd;
  logic                WindowValid;
  logic                Busy;
  logic                Done;
  logic [1:0]          State;
`ifdef SOBEL_CNT_BORDER_EN
  logic                Border;
`endif

  modport master (
    output Start, Enable, Clear,
    input  Col, Row, LineEnd, FrameEnd, WindowValid, Busy, Done, State
`ifdef SOBEL_CNT_BORDER_EN
    , input Border
`endif
  );

  modport slave (
    input  Start, Enable, Clear,
    output Col, Row, LineEnd, FrameEnd, WindowValid, Busy, Done, State
`ifdef SOBEL_CNT_BORDER_EN
    , output Border
`endif
  );
endinterface

// File: rtl/sobel_pixel_counter.sv
// Raster column/row counter with IDLE/RUN/DONE frame sequencing for the Sobel pipeline.
// Optional Border output is enabled by defining SOBEL_CNT_BORDER_EN.
module sobel_pixel_counter #(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int WIN      = 3
) (
  input  logic                 CLK,
  input  logic                 Reset,
  sobel_pixel_counter_if.slave pix
);

  if (IMG_W > 2**COL_BITS) begin : g_bad_w
    $error("sobel_pixel_counter: IMG_W does not fit in COL_BITS");
  end
  if (IMG_H > 2**ROW_BITS) begin : g_bad_h
    $error("sobel_pixel_counter: IMG_H does not fit in ROW_BITS");
  end
  if (IMG_W < WIN) begin : g_small_w
    $error("sobel_pixel_counter: IMG_W smaller than WIN");
  end
  if (IMG_H < WIN) begin : g_small_h
    $error("sobel_pixel_counter: IMG_H smaller than WIN");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_W - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_H - 1);
  localparam logic [COL_BITS-1:0] COL_WIN  = COL_BITS'(WIN - 1);
  localparam logic [ROW_BITS-1:0] ROW_WIN  = ROW_BITS'(WIN - 1);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                busy_q, done_q;

  logic run;
  logic line_end;
  logic frame_end;

  // Flags describe the pixel sitting at (col_q,row_q), i.e. the one accepted
  // if Enable is high this cycle.
  assign run       = (state_q == S_RUN);
  assign line_end  = run && (col_q == COL_LAST);
  assign frame_end = line_end && (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pix.Clear) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pix.Start) state_d = S_RUN;
        end
        S_RUN: begin
          if (pix.Enable) begin
            if (frame_end) begin
              state_d = S_DONE;
              col_d   = '0;
              row_d   = '0;
            end else if (line_end) begin
              col_d = '0;
              row_d = row_q + ROW_ONE;
            end else begin
              col_d = col_q + COL_ONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign pix.Col         = col_q;
  assign pix.Row         = row_q;
  assign pix.LineEnd     = line_end;
  assign pix.FrameEnd    = frame_end;
  assign pix.WindowValid = run && (col_q >= COL_WIN) && (row_q >= ROW_WIN);
  assign pix.Busy        = busy_q;
  assign pix.Done        = done_q;
  assign pix.State       = state_q;

`ifdef SOBEL_CNT_BORDER_EN
  assign pix.Border = run && ((col_q == '0) || (col_q == COL_LAST) ||
                              (row_q == '0) || (row_q == ROW_LAST));
`endif

endmodule

// File: tb/tb_sobel_pixel_counter.sv
// Bench for sobel_pixel_counter on a 4x3 frame: directed frame scenarios plus
// randomized Start/Enable/Clear/Reset against a pixel-index model.
module tb_sobel_pixel_counter;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int WN = 3;
  localparam int CB = 2;
  localparam int RB = 2;

  logic CLK = 1'b0;
  logic Reset;

  sobel_pixel_counter_if #(.COL_BITS(CB), .ROW_BITS(RB)) bus ();

  sobel_pixel_counter #(
    .COL_BITS(CB), .ROW_BITS(RB), .IMG_W(W), .IMG_H(H), .WIN(WN)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .pix   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: mode 0=idle 1=run 2=done, idx = pixel index in frame
  int m_mode = 0;
  int m_idx  = 0;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_mode <= 0;
      m_idx  <= 0;
    end else if (bus.Clear) begin
      m_mode <= 0;
      m_idx  <= 0;
    end else if (m_mode == 0) begin
      if (bus.Start) m_mode <= 1;
    end else if (m_mode == 1) begin
      if (bus.Enable) begin
        if (m_idx == W*H - 1) begin
          m_mode <= 2;
          m_idx  <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end else begin
      m_mode <= 0;
    end
  end

  // ---------------- compare process
  always @(negedge CLK) begin
    if (chk_en) begin
      int  ec, er;
      bit  run;
      run = (m_mode == 1);
      ec  = m_idx % W;
      er  = m_idx / W;
      check("col", int'(bus.Col), ec);
      check("row", int'(bus.Row), er);
      check("line_end", int'(bus.LineEnd), int'(run && ec == W-1));
      check("frame_end", int'(bus.FrameEnd), int'(run && m_idx == W*H-1));
      check("window_valid", int'(bus.WindowValid), int'(run && ec >= WN-1 && er >= WN-1));
      check("busy", int'(bus.Busy), int'(run));
      check("done", int'(bus.Done), int'(m_mode == 2));
`ifdef SOBEL_CNT_BORDER_EN
      check("border", int'(bus.Border),
            int'(run && (ec == 0 || ec == W-1 || er == 0 || er == H-1)));
`endif
    end
  end

  // Called just after a negedge: apply inputs for the next rising edge and
  // return just after the following negedge's compare.
  task automatic step(input bit s, input bit e, input bit c);
    bus.Start  = s;
    bus.Enable = e;
    bus.Clear  = c;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  // Hand-computed expectations for a full 4x3 frame, indexed by pixel
  int le_tab [12] = '{0,0,0,1, 0,0,0,1, 0,0,0,1};
  int fe_tab [12] = '{0,0,0,0, 0,0,0,0, 0,0,0,1};
  int wv_tab [12] = '{0,0,0,0, 0,0,0,0, 0,0,1,1};
  int bd_tab [12] = '{1,1,1,1, 1,0,0,1, 1,1,1,1};

  initial begin
    int bcount;
    Reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Enable = 1'b0;
    bus.Clear  = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_col", int'(bus.Col), 0);
    check("reset_busy", int'(bus.Busy), 0);
    check("reset_done", int'(bus.Done), 0);
    Reset  = 1'b0;
    chk_en = 1'b1;

    // Full frame with consecutive enables
    step(1, 0, 0);
    check("frame_busy", int'(bus.Busy), 1);
    bcount = 0;
    for (int i = 0; i < 12; i++) begin
      check("frame_col", int'(bus.Col), i % 4);
      check("frame_row", int'(bus.Row), i / 4);
      check("frame_le", int'(bus.LineEnd), le_tab[i]);
      check("frame_fe", int'(bus.FrameEnd), fe_tab[i]);
      check("frame_wv", int'(bus.WindowValid), wv_tab[i]);
`ifdef SOBEL_CNT_BORDER_EN
      check("frame_border", int'(bus.Border), bd_tab[i]);
      bcount += int'(bus.Border);
`endif
      step(0, 1, 0);
    end
    check("frame_done", int'(bus.Done), 1);
    check("frame_done_busy", int'(bus.Busy), 0);
    check("model_done", m_mode, 2);
`ifdef SOBEL_CNT_BORDER_EN
    check("border_count", bcount, 10);
`endif
    step(1, 1, 0);
    check("after_done_done", int'(bus.Done), 0);
    check("after_done_busy", int'(bus.Busy), 0);
    check("after_done_col", int'(bus.Col), 0);

    // Enable gating in RUN, then Enable ignored in IDLE
    step(1, 0, 0);
    step(0, 1, 0);
    check("gate_col1", int'(bus.Col), 1);
    step(0, 0, 0);
    check("gate_hold1", int'(bus.Col), 1);
    step(0, 0, 0);
    check("gate_hold2", int'(bus.Col), 1);
    step(0, 1, 0);
    check("gate_col2", int'(bus.Col), 2);
    step(0, 0, 1);
    step(0, 1, 0);
    check("idle_enable_col", int'(bus.Col), 0);
    check("idle_enable_busy", int'(bus.Busy), 0);

    // Clear beats frame completion
    step(1, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0);
    check("pre_clear_fe", int'(bus.FrameEnd), 1);
    step(0, 1, 1);
    check("clear_busy", int'(bus.Busy), 0);
    check("clear_done", int'(bus.Done), 0);
    check("clear_row", int'(bus.Row), 0);
    step(0, 0, 0);
    check("clear_no_done", int'(bus.Done), 0);
    step(1, 0, 1);
    check("start_clear_busy", int'(bus.Busy), 0);

    // Async reset mid-frame at (2,1)
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check("pre_reset_col", int'(bus.Col), 2);
    check("pre_reset_row", int'(bus.Row), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_col", int'(bus.Col), 0);
    check("async_reset_row", int'(bus.Row), 0);
    check("async_reset_busy", int'(bus.Busy), 0);
    check("async_reset_done", int'(bus.Done), 0);
    @(negedge CLK);
    #1;
    Reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit s, e, c;
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) begin
        Reset = 1'b1;
        step(s, e, c);
        Reset = 1'b0;
      end else begin
        step(s, e, c);
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
